im2col_buffer_router: RTL and testbench
=======================================

Name: im2col_buffer_router

Overview:
- Parametrised successor buffer router for the systolic array. Holds the IFMAP in a local register file (channel-fastest, then X, then Y). Streams im2col/Toeplitz windows to the array's nPEy inputs.
- Adds over the previous generation: runtime kernel width, stride and channel count; a valid/ready output handshake with backpressure; config error detection; requantised OFMAP writeback to a configurable base address.

Parameters:
- DATA_W, 8: element width.
- NUM_REG, 1024: register file depth.
- ADDR_W, $clog2(NUM_REG): derived address width.
- K_MAX, 3: maximum kernel width.
- N_LANES, K_MAX*K_MAX: derived output lane count (equals nPEy).
- N_OFMAP, 3: OFMAP elements per writeback beat (equals nPEx).
- OUT_W, 24: accumulator width from the array.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  IFMAP load strobe.
- wr_addr  in  ADDR_W  IFMAP load address.
- wr_data  in  DATA_W  IFMAP load data.
- rd_data  out  N_LANES x DATA_W  window lanes.
- rd_valid  out  1  window valid.
- rd_ready  in  1  array accepts window.
- wr_data_ofmap  in  N_OFMAP x OUT_W  accumulator results.
- ofmap_valid_i  in  1  writeback strobe.
- cfg_ifmap_width  in  16  IFMAP width W (square).
- cfg_channels  in  16  channel count C (>=1).
- cfg_kernel_w  in  4  kernel width K, 1..K_MAX.
- cfg_stride  in  2  stride S, 1..3.
- cfg_ofmap_base  in  ADDR_W  OFMAP writeback base.
- cfg_ofmap_shift  in  5  requant right shift.
- ctrl_start  in  1  start request.
- flag_busy  out  1  high while not IDLE.
- flag_done  out  1  one-cycle completion pulse.
- flag_err  out  1  one-cycle config-reject pulse.

Behaviour:
- **Clock/reset:** one clock `clk`. Reset `rst` is synchronous and active-high.
- **Reset:** state S_IDLE; all counters 0; OFMAP pointer 0; register file cleared to 0. Outputs: rd_valid=0, rd_data all 0, flag_busy=0, flag_done=0, flag_err=0. A reset mid-run abandons the run with no done pulse.
- **Config latch:** ctrl_start is sampled only in S_IDLE. On acceptance, all cfg_* values are latched. Later changes to cfg_* have no effect until the next start.
- **Derived:** OW = (W-K)/S + 1, integer floor, 16-bit.
- **Reject:** start is rejected if K==0, K>K_MAX, S==0, C==0 or W<K. On reject: flag_err pulses next cycle and the state stays S_IDLE.
- **FSM:**
  - S_IDLE -> S_RUN on accepted start.
  - S_RUN -> S_DONE on handshake of the last beat.
  - S_DONE -> S_IDLE after one cycle, with flag_done=1 in that cycle.
  - Illegal encodings -> S_IDLE.
- **Iteration order:** channel c fastest, then output x (ox), then output y (oy). One beat is one (ox, oy, c) window.
- **Lane mapping:** lane ky*K+kx, for kx, ky < K, reads address ((oy*S+ky)*W + (ox*S+kx))*C + c. Lanes >= K*K output 0.
- **Address width:** addresses are computed at 32 bits, then truncated to ADDR_W (modulo NUM_REG wrap).
- **Output path:** rd_data is combinational from the register file and the registered counters. rd_valid=1 throughout S_RUN.
  - First beat is valid the cycle after the start is accepted.
  - Counters advance only when rd_valid && rd_ready. rd_data stays stable while stalled.
- **Idle output:** outside S_RUN, rd_data = 0.
- **OFMAP writeback (any state):** on ofmap_valid_i, element i is processed as follows:
  - arithmetic right shift by the shift amount,
  - saturate to signed DATA_W,
  - write to cfg_ofmap_base + ptr + i (mod NUM_REG).
  - ptr then increments by N_OFMAP. ptr clears on accepted start.
  - The shift amount and base use the latched cfg values while flag_busy, and the live cfg values otherwise.
- **Write collision:** if wr_en and an OFMAP write target the same address in one cycle, the OFMAP write wins.
- **Read-during-write:** a write becomes visible to rd_data the cycle after it.
- **Start while busy:** ignored; no error is flagged.

Optional Feature:
- Macro: IM2COL_PAD_EN.
- **Defined:**
  - Adds input port cfg_pad (4 bits, P <= (K-1)/2).
  - OW becomes (W+2P-K)/S + 1.
  - Input coordinates become iy = oy*S+ky-P and ix = ox*S+kx-P.
  - Out-of-bounds taps (negative or >= W) output 0 and issue no memory access.
  - Start is rejected if P > (K-1)/2.
- **Undefined:** port absent; P is fixed at 0; behaviour exactly as above.

Decomposition:
- **Package `im2col_pkg`:**
  - router_state_t enum (S_IDLE, S_RUN, S_DONE).
  - im2col_cfg_t struct holding the latched config and OW.
  - requant/saturate function.
  - K_MAX_LIMIT constant.
- **Sub-module `im2col_addr_gen`:** holds the (c, ox, oy) counter nest and the advance/last logic. Outputs the window base coordinates. The top level keeps the register file, lane address mux, writeback and FSM.

Test Plan:
1. W=5, C=1, K=3, S=1, IFMAP[a]=a, rd_ready=1 -> 9 beats; beat 0 lanes = 0,1,2,5,6,7,10,11,12; beat 8 lanes = 12,13,14,17,18,19,22,23,24; flag_done pulses once, one cycle after the last beat handshake.
2. W=4, C=2, K=2, S=2 -> 8 beats; beat 1 (c=1) lanes = 1,3,9,11, lanes 4..8 = 0.
3. Case 1 with rd_ready low for 3 cycles at beat 4 -> rd_data held, still 9 beats total, done delayed by 3 cycles.
4. K=4 or W=2 with K=3 -> flag_err=1 for one cycle, flag_busy stays 0, no beats.
5. cfg_ofmap_base=100, shift=4, results {0x000100, 0xFFFF00, 0x7FFFFF} -> reg[100]=16, reg[101]=-16 (0xF0), reg[102]=127; second beat writes to 103..105.
6. Assert rst at beat 3 of case 1 -> next cycle: state IDLE, rd_valid=0, register file zeroed, no flag_done.

Source files
------------

// File: rtl/im2col_pkg.sv
`default_nettype none
// ============================================================================
// im2col_pkg : shared types, limits and requantisation helper for the
//              im2col buffer router.                        Revision 1.0
// ============================================================================
package im2col_pkg;

    localparam int K_MAX_LIMIT = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } router_state_t;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] channels;
        logic [3:0]  kernel_w;
        logic [1:0]  stride;
        logic [3:0]  pad;
        logic [15:0] ow;
    } im2col_cfg_t;

    // Arithmetic right shift followed by saturation to a signed data_w range.
    function automatic logic signed [31:0] requant_sat(
        input logic signed [31:0] acc,
        input logic [4:0]         shift,
        input int                 data_w
    );
        logic signed [31:0] shifted;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        shifted = acc >>> shift;
        max_v   = (32'sd1 <<< (data_w - 1)) - 32'sd1;
        min_v   = -(32'sd1 <<< (data_w - 1));
        if (shifted > max_v) begin
            return max_v;
        end
        if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage
`default_nettype wire

// File: rtl/im2col_buffer_router_if.sv
`default_nettype none
// ============================================================================
// im2col_buffer_router_if : IFMAP load, window stream and OFMAP writeback
//                           bus of the im2col buffer router.  Revision 1.0
// ============================================================================
interface im2col_buffer_router_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int N_LANES = 9,
    parameter int N_OFMAP = 3,
    parameter int OUT_W   = 24
);
    logic                              wr_en;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [DATA_W-1:0]                 wr_data;
    logic [N_LANES-1:0][DATA_W-1:0]    rd_data;
    logic                              rd_valid;
    logic                              rd_ready;
    logic [N_OFMAP-1:0][OUT_W-1:0]     wr_data_ofmap;
    logic                              ofmap_valid_i;

    modport master (
        output wr_en, wr_addr, wr_data, rd_ready, wr_data_ofmap, ofmap_valid_i,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_ready, wr_data_ofmap, ofmap_valid_i,
        output rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/im2col_addr_gen.sv
`default_nettype none
// ============================================================================
// im2col_addr_gen : (c, ox, oy) window counter nest with last-beat detect;
//                   emits the window base coordinates.      Revision 1.0
// ============================================================================
module im2col_addr_gen (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    input  wire logic        advance,
    input  wire logic [15:0] channels,
    input  wire logic [15:0] ow,
    input  wire logic [1:0]  stride,
    output logic [15:0]      ch,
    output logic [31:0]      win_x,
    output logic [31:0]      win_y,
    output logic             last
);
    logic [15:0] c_q, c_d;
    logic [15:0] ox_q, ox_d;
    logic [15:0] oy_q, oy_d;
    logic        c_wrap;
    logic        x_wrap;

    always_comb begin
        c_wrap = (c_q == channels - 16'd1);
        x_wrap = (ox_q == ow - 16'd1);
        last   = c_wrap && x_wrap && (oy_q == ow - 16'd1);
        c_d    = c_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        if (clear) begin
            c_d  = '0;
            ox_d = '0;
            oy_d = '0;
        end else if (advance) begin
            // Wrapping to zero after the last beat leaves the nest ready for the next run.
            if (last) begin
                c_d  = '0;
                ox_d = '0;
                oy_d = '0;
            end else if (c_wrap) begin
                c_d = '0;
                if (x_wrap) begin
                    ox_d = '0;
                    oy_d = oy_q + 16'd1;
                end else begin
                    ox_d = ox_q + 16'd1;
                end
            end else begin
                c_d = c_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q  <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            c_q  <= c_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    assign ch    = c_q;
    assign win_x = 32'(ox_q) * 32'(stride);
    assign win_y = 32'(oy_q) * 32'(stride);

endmodule
`default_nettype wire

// File: rtl/im2col_buffer_router.sv
`default_nettype none
// ============================================================================
// im2col_buffer_router : IFMAP register file streaming im2col windows to the
//   systolic array, with requantised OFMAP writeback. Optional macro
//   IM2COL_PAD_EN adds zero padding (cfg_pad port).          Revision 1.0
// ============================================================================
module im2col_buffer_router
    import im2col_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_REG = 1024,
    parameter int ADDR_W  = $clog2(NUM_REG),
    parameter int K_MAX   = K_MAX_LIMIT,
    parameter int N_LANES = K_MAX * K_MAX,
    parameter int N_OFMAP = 3,
    parameter int OUT_W   = 24
) (
    input  wire logic                clk,
    input  wire logic                rst,
    im2col_buffer_router_if.slave    bus,
    input  wire logic [15:0]         cfg_ifmap_width,
    input  wire logic [15:0]         cfg_channels,
    input  wire logic [3:0]          cfg_kernel_w,
    input  wire logic [1:0]          cfg_stride,
    input  wire logic [ADDR_W-1:0]   cfg_ofmap_base,
    input  wire logic [4:0]          cfg_ofmap_shift,
`ifdef IM2COL_PAD_EN
    input  wire logic [3:0]          cfg_pad,
`endif
    input  wire logic                ctrl_start,
    output logic                     flag_busy,
    output logic                     flag_done,
    output logic                     flag_err
);
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    router_state_t                  state_q, state_d;
    im2col_cfg_t                    cfg_q, cfg_d;
    im2col_cfg_t                    live_cfg;
    logic [ADDR_W-1:0]              base_q, base_d;
    logic [ADDR_W-1:0]              ptr_q, ptr_d;
    logic [4:0]                     shift_q, shift_d;
    logic                           err_q, err_d;
    logic [DATA_W-1:0]              rf_q [NUM_REG];
    logic [DATA_W-1:0]              rf_d [NUM_REG];
    logic [3:0]                     live_pad;
    logic                           cfg_bad;
    logic                           start_ok;
    logic                           fire;
    logic [16:0]                    ow_num;
    logic [1:0]                     ow_div;
    logic [15:0]                    ch;
    logic [31:0]                    win_x;
    logic [31:0]                    win_y;
    logic                           last;
    logic [N_LANES-1:0][DATA_W-1:0] lanes;
    logic [LANE_W-1:0]              lane_idx;
    logic [ADDR_W-1:0]              wb_base;
    logic [4:0]                     wb_shift;

`ifdef IM2COL_PAD_EN
    assign live_pad = cfg_pad;
`else
    assign live_pad = 4'd0;
`endif

    always_comb begin
        cfg_bad = (cfg_kernel_w == 4'd0)
               || (int'(cfg_kernel_w) > K_MAX)
               || (cfg_stride == 2'd0)
               || (cfg_channels == 16'd0)
               || (cfg_ifmap_width < 16'(cfg_kernel_w))
               || (live_pad > ((cfg_kernel_w - 4'd1) >> 1));
        ow_num  = 17'(cfg_ifmap_width) + 17'({live_pad, 1'b0}) - 17'(cfg_kernel_w);
        ow_div  = (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
        live_cfg.width    = cfg_ifmap_width;
        live_cfg.channels = cfg_channels;
        live_cfg.kernel_w = cfg_kernel_w;
        live_cfg.stride   = cfg_stride;
        live_cfg.pad      = live_pad;
        live_cfg.ow       = 16'(ow_num / 17'(ow_div)) + 16'd1;
    end

    assign start_ok = (state_q == S_IDLE) && ctrl_start && !cfg_bad;
    assign fire     = (state_q == S_RUN) && bus.rd_ready;

    im2col_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .advance  (fire),
        .channels (cfg_q.channels),
        .ow       (cfg_q.ow),
        .stride   (cfg_q.stride),
        .ch       (ch),
        .win_x    (win_x),
        .win_y    (win_y),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        base_d  = base_q;
        shift_d = shift_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cfg_d   = live_cfg;
                        base_d  = cfg_ofmap_base;
                        shift_d = cfg_ofmap_shift;
                    end
                end
            end
            S_RUN: begin
                if (fire && last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Window taps; out-of-range taps (only reachable with padding) read as zero.
    always_comb begin
        int iy;
        int ix;
        int kw;
        int wd;
        lanes    = '0;
        lane_idx = '0;
        iy       = 0;
        ix       = 0;
        kw       = int'(cfg_q.kernel_w);
        wd       = int'(cfg_q.width);
        if (state_q == S_RUN) begin
            for (int ky = 0; ky < K_MAX; ky++) begin
                for (int kx = 0; kx < K_MAX; kx++) begin
                    iy = int'(win_y) + ky - int'(cfg_q.pad);
                    ix = int'(win_x) + kx - int'(cfg_q.pad);
                    if (ky < kw && kx < kw && iy >= 0 && iy < wd && ix >= 0 && ix < wd) begin
                        lane_idx        = LANE_W'(ky * kw + kx);
                        lanes[lane_idx] = rf_q[ADDR_W'((iy * wd + ix) * int'(cfg_q.channels) + int'(ch))];
                    end
                end
            end
        end
    end

    // OFMAP writes are applied after IFMAP loads so they win on an address clash.
    always_comb begin
        rf_d     = rf_q;
        ptr_d    = ptr_q;
        wb_base  = flag_busy ? base_q  : cfg_ofmap_base;
        wb_shift = flag_busy ? shift_q : cfg_ofmap_shift;
        if (bus.wr_en) begin
            rf_d[bus.wr_addr] = bus.wr_data;
        end
        if (bus.ofmap_valid_i) begin
            for (int i = 0; i < N_OFMAP; i++) begin
                rf_d[wb_base + ptr_q + ADDR_W'(i)] =
                    DATA_W'(requant_sat(32'(signed'(bus.wr_data_ofmap[i])), wb_shift, DATA_W));
            end
            ptr_d = ptr_q + ADDR_W'(N_OFMAP);
        end
        if (start_ok) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            base_q  <= base_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            rf_q    <= rf_d;
        end
    end

    assign bus.rd_data  = lanes;
    assign bus.rd_valid = (state_q == S_RUN);
    assign flag_busy    = (state_q != S_IDLE);
    assign flag_done    = (state_q == S_DONE);
    assign flag_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_im2col_buffer_router.sv
`default_nettype none
// Randomised bench for im2col_buffer_router against an array-based model of
// the register file and the im2col window rules.
module tb_im2col_buffer_router;
    localparam int DATA_W  = 8;
    localparam int NUM_REG = 1024;
    localparam int ADDR_W  = 10;
    localparam int K_MAX   = 3;
    localparam int N_LANES = 9;
    localparam int N_OFMAP = 3;
    localparam int OUT_W   = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_ifmap_width;
    logic [15:0] cfg_channels;
    logic [3:0]  cfg_kernel_w;
    logic [1:0]  cfg_stride;
    logic [9:0]  cfg_ofmap_base;
    logic [4:0]  cfg_ofmap_shift;
    logic        ctrl_start;
    logic        flag_busy;
    logic        flag_done;
    logic        flag_err;
`ifdef IM2COL_PAD_EN
    logic [3:0]  cfg_pad = 4'd0;
`endif

    logic [7:0]  mem [NUM_REG];
    int          ptr_m  = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    im2col_buffer_router_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_LANES(N_LANES), .N_OFMAP(N_OFMAP), .OUT_W(OUT_W)
    ) bus ();

    im2col_buffer_router #(
        .DATA_W(DATA_W), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .K_MAX(K_MAX),
        .N_LANES(N_LANES), .N_OFMAP(N_OFMAP), .OUT_W(OUT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cfg_ifmap_width (cfg_ifmap_width),
        .cfg_channels    (cfg_channels),
        .cfg_kernel_w    (cfg_kernel_w),
        .cfg_stride      (cfg_stride),
        .cfg_ofmap_base  (cfg_ofmap_base),
        .cfg_ofmap_shift (cfg_ofmap_shift),
`ifdef IM2COL_PAD_EN
        .cfg_pad         (cfg_pad),
`endif
        .ctrl_start      (ctrl_start),
        .flag_busy       (flag_busy),
        .flag_done       (flag_done),
        .flag_err        (flag_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] window(int w, int c, int k, int s, int ox, int oy, int chn);
        logic [127:0] v;
        v = '0;
        for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
                v[(ky * k + kx) * 8 +: 8] = mem[(((oy * s + ky) * w + (ox * s + kx)) * c + chn) % NUM_REG];
            end
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int a = 0; a < NUM_REG; a++) mem[a] = 8'h00;
        ptr_m = 0;
    endtask

    task automatic load(input bit rnd);
        for (int a = 0; a < 128; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 10'(a);
            bus.wr_data = rnd ? 8'($urandom) : 8'(a);
            mem[a]      = bus.wr_data;
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
    endtask

    // mode 0: always ready, 1: 3-cycle stall at beat 4, 2: random ready
    task automatic run(input int w, input int c, input int k, input int s, input int mode,
                       input int abort_at, output int cyc);
        logic [127:0] q[$];
        int ow;
        int idx;
        int stall;
        int total;
        ow    = (w - k) / s + 1;
        idx   = 0;
        stall = 0;
        for (int oy = 0; oy < ow; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int chn = 0; chn < c; chn++)
                    q.push_back(window(w, c, k, s, ox, oy, chn));
        total           = q.size();
        cfg_ifmap_width = 16'(w);
        cfg_channels    = 16'(c);
        cfg_kernel_w    = 4'(k);
        cfg_stride      = 2'(s);
        ctrl_start      = 1'b1;
        @(posedge clk); #1;
        ctrl_start      = 1'b0;
        ptr_m           = 0;
        cfg_ifmap_width = 16'($urandom);
        cfg_channels    = 16'($urandom);
        cfg_kernel_w    = 4'($urandom);
        cfg_stride      = 2'($urandom);
        cyc = 0;
        while (idx < total && cyc < 4 * total + 50) begin
            if (idx == abort_at) break;
            case (mode)
                0: bus.rd_ready = 1'b1;
                1: begin
                    if (idx == 4 && stall < 3) begin
                        bus.rd_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.rd_ready = 1'b1;
                    end
                end
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("rd_valid_run", bus.rd_valid, 1'b1);
            check("beat_lanes", bus.rd_data, q[idx]);
            if (bus.rd_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        if (abort_at < 0) begin
            check("beat_count", idx, total);
            @(negedge clk);
            check("done_pulse", flag_done, 1'b1);
            check("valid_after_last", bus.rd_valid, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_once", flag_done, 1'b0);
            check("busy_after_done", flag_busy, 1'b0);
            check("idle_rd_data", bus.rd_data, '0);
            @(posedge clk); #1;
        end
    endtask

    task automatic reject(input int w, input int c, input int k, input int s);
        cfg_ifmap_width = 16'(w);
        cfg_channels    = 16'(c);
        cfg_kernel_w    = 4'(k);
        cfg_stride      = 2'(s);
        ctrl_start      = 1'b1;
        @(posedge clk); #1;
        ctrl_start      = 1'b0;
        @(negedge clk);
        check("err_pulse", flag_err, 1'b1);
        check("err_busy", flag_busy, 1'b0);
        check("err_valid", bus.rd_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_once", flag_err, 1'b0);
        check("err_busy2", flag_busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic ofmap_beat(input logic [71:0] res, input logic [9:0] base, input logic [4:0] sh,
                              input bit collide, input logic [9:0] caddr, input logic [7:0] cdata);
        int v;
        cfg_ofmap_base    = base;
        cfg_ofmap_shift   = sh;
        bus.wr_data_ofmap = res;
        bus.ofmap_valid_i = 1'b1;
        if (collide) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = caddr;
            bus.wr_data = cdata;
            mem[caddr]  = cdata;
        end
        for (int i = 0; i < N_OFMAP; i++) begin
            v = int'(signed'(res[i * 24 +: 24]));
            v = v >>> sh;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            mem[(int'(base) + ptr_m + i) % NUM_REG] = 8'(v);
        end
        ptr_m += N_OFMAP;
        @(posedge clk); #1;
        bus.ofmap_valid_i = 1'b0;
        bus.wr_en         = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int w, c, k, s;
        rst               = 1'b1;
        ctrl_start        = 1'b0;
        cfg_ifmap_width   = '0;
        cfg_channels      = '0;
        cfg_kernel_w      = '0;
        cfg_stride        = '0;
        cfg_ofmap_base    = '0;
        cfg_ofmap_shift   = '0;
        bus.wr_en         = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.rd_ready      = 1'b0;
        bus.wr_data_ofmap = '0;
        bus.ofmap_valid_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.rd_valid, 1'b0);
        check("rst_busy", flag_busy, 1'b0);
        check("rst_done", flag_done, 1'b0);
        check("rst_err", flag_err, 1'b0);
        check("rst_rd_data", bus.rd_data, '0);
        @(posedge clk); #1;

        load(1'b0);
        run(5, 1, 3, 1, 0, -1, cyc);
        check("case1_cycles", cyc, 9);
        run(4, 2, 2, 2, 0, -1, cyc);
        check("case2_cycles", cyc, 8);
        run(5, 1, 3, 1, 1, -1, cyc);
        check("stall_cycles", cyc, 12);

        reject(5, 1, 4, 1);
        reject(2, 1, 3, 1);
        reject(5, 0, 3, 1);
        reject(5, 1, 3, 0);

        ofmap_beat({24'h7FFFFF, 24'hFFFF00, 24'h000100}, 10'd100, 5'd4, 1'b0, 10'd0, 8'h00);
        ofmap_beat({24'h7FFFFF, 24'hFFFF00, 24'h000100}, 10'd100, 5'd4, 1'b1, 10'd104, 8'h55);
        run(11, 1, 1, 1, 2, -1, cyc);

        load(1'b1);
        for (int it = 0; it < 4; it++) begin
            w = $urandom_range(3, 6);
            k = $urandom_range(1, 3);
            s = $urandom_range(1, 3);
            c = $urandom_range(1, 3);
            run(w, c, k, s, 2, -1, cyc);
        end

        run(5, 1, 3, 1, 0, 3, cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("abort_valid", bus.rd_valid, 1'b0);
        check("abort_busy", flag_busy, 1'b0);
        check("abort_done", flag_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_no_done", flag_done, 1'b0);
        end
        @(posedge clk); #1;
        run(11, 1, 1, 1, 0, -1, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
